decoder_leaf_n: RTL and testbench
=================================

Name: decoder_leaf_n

Overview:
- Clocked, parametrised successor to the two-way leaf decoder used in the NoC tree.
- Accepts packets of W-bit flits on one valid/ready input and routes each whole packet to one of NUM_OUT outputs, chosen by the low SEL_W address bits of the head flit.
- Strips those address bits, and reports each routing decision on a side (select) channel.
- Adds an input FIFO, per-output holding registers, N-way fan-out and invalid-destination dropping.

Parameters:
- W, 9: flit width; bit W-1 is the tail flag, bits W-2:0 are payload.
- NUM_OUT, 2: number of output ports, 2..16.
- DEPTH, 4: input FIFO depth; power of two, >=2.
- SEL_W, $clog2(NUM_OUT): address bits consumed per leaf; must be <= W-1.
- CNT_W, 16: packet counter width (optional feature only).

Ports:
- CLK  in  1  clock; all state on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- in_data  in  W  input flit.
- in_valid  in  1  input flit valid.
- in_ready  out  1  FIFO not full.
- out_data  out  NUM_OUT*W  port p occupies bits [p*W +: W].
- out_valid  out  NUM_OUT  per-port valid.
- out_ready  in  NUM_OUT  per-port ready.
- sel_data  out  SEL_W  destination of the current packet.
- sel_valid  out  1  select token valid.
- sel_ready  in  1  select token accepted.
- drop_pulse  out  1  one-cycle pulse on the head flit of each dropped packet.

Behaviour:
- Reset (async assert, sync release):
  - FIFO empty; FSM in HEAD.
  - out_valid=0, sel_valid=0, drop_pulse=0, in_ready=0 while RESET is high.
  - All data registers 0.
  - Reset mid-packet discards every buffered flit; no partial packet resumes.
- Input FIFO:
  - Push on in_valid&&in_ready.
  - in_ready = !full, computed from registered state; no combinational path from out_ready.
  - No bypass: a flit pushed at edge k is at the FIFO head after edge k.
- Output holding registers, one entry per port:
  - A register loads when it is empty or draining this cycle (out_valid[p]&&out_ready[p]).
  - Minimum latency: flit accepted at edge k -> out_valid asserted after edge k+1.
  - Full throughput: one flit per cycle with out_ready held high.
- FSM states:
  - HEAD: the FIFO head is a head flit. sel = payload[SEL_W-1:0].
    - If sel<NUM_OUT, pop only when out register[sel] can load AND the sel register is empty or draining.
    - On pop: load out register[sel] with {tail, payload>>SEL_W (zero-filled)}, load sel_data=sel, set sel_valid.
    - If tail=0, latch cur_sel and go to BODY; if tail=1 (single-flit packet), stay in HEAD.
  - HEAD with sel>=NUM_OUT (non-power-of-two NUM_OUT only):
    - Pop the head flit without forwarding it and pulse drop_pulse.
    - If tail=0, go to DROP.
  - BODY: pop when out register[cur_sel] can load; forward the flit unmodified. Tail flit -> HEAD.
  - DROP: pop one flit per cycle unconditionally, discarding it. Tail flit -> HEAD.
- Other rules:
  - Only one flit leaves the FIFO per cycle.
  - Backpressure on the active port stalls the packet but never blocks other ports' registers from draining.
  - sel_valid back-pressure blocks only the next head flit.

Optional Feature:
- Macro: DECODER_LEAF_PKT_COUNT_EN.
- With the macro:
  - Adds output pkt_count, NUM_OUT*CNT_W bits, one counter per port.
  - A port's counter increments when that port's tail flit is loaded into its register.
  - Counters saturate at all-ones and are cleared by RESET.
- Without the macro: the port and the counters are absent; behaviour is otherwise identical.

Decomposition:
- decoder_leaf_pkg holds:
  - state_t enum {HEAD, BODY, DROP}.
  - TAIL_BIT index function of W.
  - Function that extracts sel and shifts the payload.
- Sub-module fifo_sync (W, DEPTH):
  - Ports: push/pop, full/empty, head data.
  - Pointer wrap is by natural overflow; occupancy counter is DEPTH+1 states wide.

Test Plan:
- W=9, NUM_OUT=2: head 0_00000001, body 0_10101010, tail 1_11110000, all out_ready=1 -> out 1 receives 0_00000000, 0_10101010, 1_11110000; sel_data=1 pulses once; out 0 stays idle.
- Single-flit packet 1_00000010 with NUM_OUT=4 -> out 2 receives 1_00000000; sel=2; FSM back in HEAD on the next cycle; 100 back-to-back single-flit packets at one per cycle.
- NUM_OUT=3, head sel=3 in a 3-flit packet -> drop_pulse=1 for one cycle; no out_valid, no sel_valid; next packet to port 0 is delivered normally.
- Hold out_ready[0]=0 while pushing 6 flits, DEPTH=4 -> in_ready falls after 5 accepted (4 FIFO + 1 holding); release -> all flits delivered in order, none lost.
- sel_ready=0 with two queued packets -> first packet flows, second head waits; raising sel_ready releases it with sel tokens in order.
- Assert RESET mid-BODY -> all outputs 0 immediately; after release, a new packet routes correctly; with DECODER_LEAF_PKT_COUNT_EN, pkt_count reads 0 after reset, then 1 on the new packet's port.

Source files
------------

// File: rtl/decoder_leaf_pkg.sv
// Shared types and flit helpers for the parametrised NoC leaf decoder.
package decoder_leaf_pkg;

  typedef enum logic [1:0] {
    HEAD = 2'd0,
    BODY = 2'd1,
    DROP = 2'd2
  } state_t;

  // Helpers work on a widest-case payload; callers cast the result back down.
  localparam int unsigned MAX_W     = 64;
  localparam int unsigned MAX_SEL_W = 4;

  function automatic int unsigned tail_bit(input int unsigned w);
    return w - 32'd1;
  endfunction

  function automatic logic [MAX_SEL_W-1:0] extract_sel(input logic [MAX_W-1:0] payload,
                                                       input int unsigned sel_w);
    logic [MAX_SEL_W-1:0] mask_s;
    mask_s = ~({MAX_SEL_W{1'b1}} << sel_w);
    return MAX_SEL_W'(payload) & mask_s;
  endfunction

  function automatic logic [MAX_W-1:0] shift_payload(input logic [MAX_W-1:0] payload,
                                                     input int unsigned sel_w);
    return payload >> sel_w;
  endfunction

endpackage

// File: rtl/decoder_leaf_fifo_sync.sv
// Synchronous input FIFO; pointers wrap by natural overflow, no bypass path.
module fifo_sync #(
  parameter int W     = 9,
  parameter int DEPTH = 4
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head_data
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic [AW:0]   count_next_s;
  logic          full_r;
  logic          empty_r;
  logic          do_push_s;
  logic          do_pop_s;

  // Next occupancy from this cycle's accepted push/pop.
  always_comb begin
    do_push_s    = push && !full_r;
    do_pop_s     = pop && !empty_r;
    count_next_s = count_r;
    if (do_push_s && !do_pop_s) begin
      count_next_s = count_r + (AW+1)'(1'b1);
    end else if (!do_push_s && do_pop_s) begin
      count_next_s = count_r - (AW+1)'(1'b1);
    end else begin
      count_next_s = count_r;
    end
  end

  // Storage, pointers and registered flags; full reads high during reset so the input stays closed.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {W{1'b0}};
      end
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
      full_r   <= 1'b1;
      empty_r  <= 1'b1;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + AW'(1'b1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      count_r <= count_next_s;
      full_r  <= (count_next_s == (AW+1)'(DEPTH));
      empty_r <= (count_next_s == {(AW+1){1'b0}});
    end
  end

  assign full      = full_r;
  assign empty     = empty_r;
  assign head_data = mem_r[rd_ptr_r];

endmodule

// File: rtl/decoder_leaf_n.sv
// N-way NoC leaf decoder with input FIFO, per-port holding registers and invalid-destination drop.
// Optional per-port packet counters are enabled with DECODER_LEAF_PKT_COUNT_EN.
module decoder_leaf_n
  import decoder_leaf_pkg::*;
#(
  parameter int W       = 9,
  parameter int NUM_OUT = 2,
  parameter int DEPTH   = 4,
  parameter int SEL_W   = $clog2(NUM_OUT),
  parameter int CNT_W   = 16
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [W-1:0]         in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [NUM_OUT*W-1:0] out_data,
  output logic [NUM_OUT-1:0]   out_valid,
  input  logic [NUM_OUT-1:0]   out_ready,
  output logic [SEL_W-1:0]     sel_data,
  output logic                 sel_valid,
  input  logic                 sel_ready,
  output logic                 drop_pulse
`ifdef DECODER_LEAF_PKT_COUNT_EN
  ,
  output logic [NUM_OUT*CNT_W-1:0] pkt_count
`endif
);

  localparam int unsigned       TAIL      = tail_bit(W);
  localparam int unsigned       PAD_W     = MAX_W - (W - 1);
  localparam logic [MAX_SEL_W:0] NUM_OUT_L = (MAX_SEL_W+1)'(NUM_OUT);

  logic [W-1:0]         fifo_head_s;
  logic                 fifo_full_s;
  logic                 fifo_empty_s;
  logic                 pop_s;
  logic                 head_tail_s;
  logic [MAX_W-1:0]     payload_ext_s;
  logic [MAX_SEL_W-1:0] sel_ext_s;
  logic [SEL_W-1:0]     sel_s;
  logic                 sel_ok_s;
  logic [W-2:0]         shifted_s;
  logic [NUM_OUT-1:0]   can_load_s;
  logic                 sel_free_s;
  logic                 load_en_s;
  logic [SEL_W-1:0]     tgt_s;
  logic [W-1:0]         load_data_s;
  logic                 sel_load_s;
  logic                 drop_s;
  state_t               state_next_s;

  state_t               state_r;
  logic [SEL_W-1:0]     cur_sel_r;
  logic [W-1:0]         out_data_r [NUM_OUT];
  logic [NUM_OUT-1:0]   out_valid_r;
  logic [SEL_W-1:0]     sel_data_r;
  logic                 sel_valid_r;
  logic                 drop_pulse_r;

  fifo_sync #(.W(W), .DEPTH(DEPTH)) u_fifo (
    .CLK       (CLK),
    .RESET     (RESET),
    .push      (in_valid),
    .push_data (in_data),
    .pop       (pop_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .head_data (fifo_head_s)
  );

  assign in_ready    = !fifo_full_s;
  assign head_tail_s = fifo_head_s[TAIL];
  assign can_load_s  = ~out_valid_r | out_ready;
  assign sel_free_s  = !sel_valid_r || sel_ready;

  // Destination and stripped payload of the flit currently at the FIFO head.
  always_comb begin
    payload_ext_s = {{PAD_W{1'b0}}, fifo_head_s[W-2:0]};
    sel_ext_s     = extract_sel(payload_ext_s, SEL_W);
    shifted_s     = (W-1)'(shift_payload(payload_ext_s, SEL_W));
    sel_s         = sel_ext_s[SEL_W-1:0];
    sel_ok_s      = ({1'b0, sel_ext_s} < NUM_OUT_L);
  end

  // Per-cycle routing decision: at most one pop, one register load and one select token.
  always_comb begin
    pop_s        = 1'b0;
    load_en_s    = 1'b0;
    tgt_s        = cur_sel_r;
    load_data_s  = fifo_head_s;
    sel_load_s   = 1'b0;
    drop_s       = 1'b0;
    state_next_s = state_r;
    case (state_r)
      HEAD: begin
        if (fifo_empty_s) begin
          pop_s = 1'b0;
        end else if (!sel_ok_s) begin
          pop_s        = 1'b1;
          drop_s       = 1'b1;
          state_next_s = head_tail_s ? HEAD : DROP;
        end else if (can_load_s[sel_s] && sel_free_s) begin
          pop_s        = 1'b1;
          load_en_s    = 1'b1;
          tgt_s        = sel_s;
          load_data_s  = {head_tail_s, shifted_s};
          sel_load_s   = 1'b1;
          state_next_s = head_tail_s ? HEAD : BODY;
        end else begin
          pop_s = 1'b0;
        end
      end
      BODY: begin
        if (!fifo_empty_s && can_load_s[cur_sel_r]) begin
          pop_s        = 1'b1;
          load_en_s    = 1'b1;
          state_next_s = head_tail_s ? HEAD : BODY;
        end else begin
          pop_s = 1'b0;
        end
      end
      DROP: begin
        if (!fifo_empty_s) begin
          pop_s        = 1'b1;
          state_next_s = head_tail_s ? HEAD : DROP;
        end else begin
          pop_s = 1'b0;
        end
      end
      default: begin
        state_next_s = HEAD;
      end
    endcase
  end

  // FSM state plus the registered output, select and drop channels.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r      <= HEAD;
      cur_sel_r    <= {SEL_W{1'b0}};
      out_valid_r  <= {NUM_OUT{1'b0}};
      sel_data_r   <= {SEL_W{1'b0}};
      sel_valid_r  <= 1'b0;
      drop_pulse_r <= 1'b0;
      for (int p = 0; p < NUM_OUT; p++) begin
        out_data_r[p] <= {W{1'b0}};
      end
    end else begin
      state_r      <= state_next_s;
      drop_pulse_r <= drop_s;
      if (sel_load_s) begin
        cur_sel_r   <= sel_s;
        sel_data_r  <= sel_s;
        sel_valid_r <= 1'b1;
      end else if (sel_ready) begin
        sel_valid_r <= 1'b0;
      end
      for (int p = 0; p < NUM_OUT; p++) begin
        if (load_en_s && (tgt_s == SEL_W'(p))) begin
          out_data_r[p]  <= load_data_s;
          out_valid_r[p] <= 1'b1;
        end else if (out_ready[p]) begin
          out_valid_r[p] <= 1'b0;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_out
    assign out_data[g*W +: W] = out_data_r[g];
  end

  assign out_valid  = out_valid_r;
  assign sel_data   = sel_data_r;
  assign sel_valid  = sel_valid_r;
  assign drop_pulse = drop_pulse_r;

`ifdef DECODER_LEAF_PKT_COUNT_EN
  logic [CNT_W-1:0] pkt_cnt_r [NUM_OUT];

  // Saturating per-port count of tail flits loaded into the holding registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int p = 0; p < NUM_OUT; p++) begin
        pkt_cnt_r[p] <= {CNT_W{1'b0}};
      end
    end else begin
      for (int p = 0; p < NUM_OUT; p++) begin
        if (load_en_s && (tgt_s == SEL_W'(p)) && load_data_s[TAIL] &&
            (pkt_cnt_r[p] != {CNT_W{1'b1}})) begin
          pkt_cnt_r[p] <= pkt_cnt_r[p] + CNT_W'(1'b1);
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_cnt
    assign pkt_count[g*CNT_W +: CNT_W] = pkt_cnt_r[g];
  end
`endif

endmodule

// File: tb/tb_decoder_leaf_n.sv
// Directed self-checking bench for decoder_leaf_n with 2-, 4- and 3-port instances.
`timescale 1ns/1ps
module tb_decoder_leaf_n;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  logic [8:0]  a_in_data;  logic a_in_valid;  logic a_in_ready;
  logic [17:0] a_out_data; logic [1:0] a_out_valid; logic [1:0] a_out_ready;
  logic [0:0]  a_sel_data; logic a_sel_valid; logic a_sel_ready; logic a_drop;

  logic [8:0]  b_in_data;  logic b_in_valid;  logic b_in_ready;
  logic [35:0] b_out_data; logic [3:0] b_out_valid; logic [3:0] b_out_ready;
  logic [1:0]  b_sel_data; logic b_sel_valid; logic b_sel_ready; logic b_drop;

  logic [8:0]  c_in_data;  logic c_in_valid;  logic c_in_ready;
  logic [26:0] c_out_data; logic [2:0] c_out_valid; logic [2:0] c_out_ready;
  logic [1:0]  c_sel_data; logic c_sel_valid; logic c_sel_ready; logic c_drop;

`ifdef DECODER_LEAF_PKT_COUNT_EN
  logic [31:0] a_pkt_count;
  logic [63:0] b_pkt_count;
  logic [47:0] c_pkt_count;
`endif

  decoder_leaf_n #(.W(9), .NUM_OUT(2), .DEPTH(4)) u_a (
    .CLK(CLK), .RESET(RESET), .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .sel_data(a_sel_data), .sel_valid(a_sel_valid), .sel_ready(a_sel_ready), .drop_pulse(a_drop)
`ifdef DECODER_LEAF_PKT_COUNT_EN
    , .pkt_count(a_pkt_count)
`endif
  );

  decoder_leaf_n #(.W(9), .NUM_OUT(4), .DEPTH(4)) u_b (
    .CLK(CLK), .RESET(RESET), .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .sel_data(b_sel_data), .sel_valid(b_sel_valid), .sel_ready(b_sel_ready), .drop_pulse(b_drop)
`ifdef DECODER_LEAF_PKT_COUNT_EN
    , .pkt_count(b_pkt_count)
`endif
  );

  decoder_leaf_n #(.W(9), .NUM_OUT(3), .DEPTH(4)) u_c (
    .CLK(CLK), .RESET(RESET), .in_data(c_in_data), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .out_data(c_out_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .sel_data(c_sel_data), .sel_valid(c_sel_valid), .sel_ready(c_sel_ready), .drop_pulse(c_drop)
`ifdef DECODER_LEAF_PKT_COUNT_EN
    , .pkt_count(c_pkt_count)
`endif
  );

  task automatic test_reset();
    RESET = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checks++; if (a_in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready_a got=%b exp=0", a_in_ready); end
    checks++; if (b_in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready_b got=%b exp=0", b_in_ready); end
    checks++; if (a_out_valid !== 2'b00) begin failures++; $display("FAIL reset_out_valid_a got=%b exp=00", a_out_valid); end
    checks++; if (c_out_valid !== 3'b000) begin failures++; $display("FAIL reset_out_valid_c got=%b exp=000", c_out_valid); end
    checks++; if (a_sel_valid !== 1'b0) begin failures++; $display("FAIL reset_sel_valid_a got=%b exp=0", a_sel_valid); end
    checks++; if (a_drop !== 1'b0) begin failures++; $display("FAIL reset_drop_a got=%b exp=0", a_drop); end
    checks++; if (a_out_data !== 18'd0) begin failures++; $display("FAIL reset_out_data_a got=%h exp=0", a_out_data); end
    checks++; if (b_sel_data !== 2'd0) begin failures++; $display("FAIL reset_sel_data_b got=%h exp=0", b_sel_data); end
    @(posedge CLK); #1;
    RESET = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready_a got=%b exp=1", a_in_ready); end
    checks++; if (c_in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready_c got=%b exp=1", c_in_ready); end
    @(posedge CLK); #1;
  endtask

  task automatic test_basic_route();
    logic [8:0] flits [3];
    logic [8:0] exp_d [3];
    logic [8:0] got [$];
    int pushed = 0;
    int sel_tokens = 0;
    int out0_seen = 0;
    bit acc;
    flits = '{9'b0_00000001, 9'b0_10101010, 9'b1_11110000};
    exp_d = '{9'b0_00000000, 9'b0_10101010, 9'b1_11110000};
    a_out_ready = 2'b11; a_sel_ready = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      a_in_valid = (pushed < 3);
      if (pushed < 3) a_in_data = flits[pushed]; else a_in_data = 9'd0;
      @(negedge CLK);
      acc = a_in_valid && a_in_ready;
      if (a_out_valid[1]) got.push_back(a_out_data[17:9]);
      if (a_out_valid[0]) out0_seen++;
      if (a_sel_valid) begin
        sel_tokens++;
        checks++; if (a_sel_data !== 1'b1) begin failures++; $display("FAIL basic_sel_data got=%b exp=1", a_sel_data); end
      end
      @(posedge CLK); #1;
      if (acc) pushed++;
    end
    a_in_valid = 1'b0;
    checks++; if (got.size() != 3) begin failures++; $display("FAIL basic_count got=%0d exp=3", got.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= got.size() || got[i] !== exp_d[i]) begin
        failures++; $display("FAIL basic_flit%0d got=%b exp=%b", i, (i < got.size()) ? got[i] : 9'h1ff, exp_d[i]);
      end
    end
    checks++; if (sel_tokens != 1) begin failures++; $display("FAIL basic_sel_tokens got=%0d exp=1", sel_tokens); end
    checks++; if (out0_seen != 0) begin failures++; $display("FAIL basic_out0_idle got=%0d exp=0", out0_seen); end
  endtask

  task automatic test_single_flit_stream();
    logic [8:0] flit_q [$];
    logic [8:0] exp_d [$];
    logic [1:0] exp_p [$];
    int pushed = 0, delivered = 0, stalls = 0, sel_seen = 0;
    int first_cyc = -1, last_cyc = -1, first_port = -1;
    logic [8:0] first_data = 9'd0;
    bit acc;
    for (int i = 0; i < 101; i++) begin
      logic [7:0] iv;
      iv = 8'(i);
      if (i == 0) begin
        flit_q.push_back(9'b1_00000010); exp_d.push_back(9'b1_00000000); exp_p.push_back(2'd2);
      end else begin
        flit_q.push_back({1'b1, iv[5:0], iv[1:0]}); exp_d.push_back({1'b1, 2'b00, iv[5:0]}); exp_p.push_back(iv[1:0]);
      end
    end
    b_out_ready = 4'b1111; b_sel_ready = 1'b1;
    for (int cyc = 0; cyc < 140; cyc++) begin
      b_in_valid = (pushed < 101);
      if (pushed < 101) b_in_data = flit_q[pushed]; else b_in_data = 9'd0;
      @(negedge CLK);
      acc = b_in_valid && b_in_ready;
      if (b_in_valid && !b_in_ready) stalls++;
      for (int p = 0; p < 4; p++) begin
        if (b_out_valid[p]) begin
          if (first_cyc < 0) begin first_cyc = cyc; first_port = p; first_data = b_out_data[p*9 +: 9]; end
          last_cyc = cyc;
          checks++;
          if (delivered >= 101 || 2'(p) !== exp_p[delivered] || b_out_data[p*9 +: 9] !== exp_d[delivered]) begin
            failures++; $display("FAIL stream_flit%0d port=%0d got=%b", delivered, p, b_out_data[p*9 +: 9]);
          end
          delivered++;
        end
      end
      if (b_sel_valid) begin
        checks++;
        if (sel_seen >= 101 || b_sel_data !== exp_p[sel_seen]) begin
          failures++; $display("FAIL stream_sel%0d got=%0d", sel_seen, b_sel_data);
        end
        sel_seen++;
      end
      @(posedge CLK); #1;
      if (acc) pushed++;
    end
    b_in_valid = 1'b0;
    checks++; if (first_port != 2) begin failures++; $display("FAIL single_port got=%0d exp=2", first_port); end
    checks++; if (first_data !== 9'b1_00000000) begin failures++; $display("FAIL single_data got=%b exp=100000000", first_data); end
    checks++; if (delivered != 101) begin failures++; $display("FAIL stream_count got=%0d exp=101", delivered); end
    checks++; if (sel_seen != 101) begin failures++; $display("FAIL stream_sel_count got=%0d exp=101", sel_seen); end
    checks++; if (stalls != 0) begin failures++; $display("FAIL stream_stalls got=%0d exp=0", stalls); end
    checks++; if (first_cyc != 2 || last_cyc - first_cyc != 100) begin
      failures++; $display("FAIL stream_rate first=%0d last=%0d exp first=2 span=100", first_cyc, last_cyc);
    end
  endtask

  task automatic test_drop();
    logic [8:0] flits [5];
    logic [8:0] exp_d [2];
    int pushed = 0, delivered = 0, drops = 0, sels = 0;
    bit acc;
    flits = '{9'b0_00000011, 9'b0_01010101, 9'b1_00001111, 9'b0_00000100, 9'b1_11001100};
    exp_d = '{9'b0_00000001, 9'b1_11001100};
    c_out_ready = 3'b111; c_sel_ready = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      c_in_valid = (pushed < 5);
      if (pushed < 5) c_in_data = flits[pushed]; else c_in_data = 9'd0;
      @(negedge CLK);
      acc = c_in_valid && c_in_ready;
      if (c_drop) drops++;
      for (int p = 0; p < 3; p++) begin
        if (c_out_valid[p]) begin
          checks++;
          if (delivered >= 2 || p != 0 || c_out_data[p*9 +: 9] !== exp_d[delivered]) begin
            failures++; $display("FAIL drop_flit%0d port=%0d got=%b", delivered, p, c_out_data[p*9 +: 9]);
          end
          delivered++;
        end
      end
      if (c_sel_valid) begin
        sels++;
        checks++; if (c_sel_data !== 2'd0) begin failures++; $display("FAIL drop_sel_data got=%0d exp=0", c_sel_data); end
      end
      @(posedge CLK); #1;
      if (acc) pushed++;
    end
    c_in_valid = 1'b0;
    checks++; if (drops != 1) begin failures++; $display("FAIL drop_pulse_cycles got=%0d exp=1", drops); end
    checks++; if (delivered != 2) begin failures++; $display("FAIL drop_delivered got=%0d exp=2", delivered); end
    checks++; if (sels != 1) begin failures++; $display("FAIL drop_sel_tokens got=%0d exp=1", sels); end
  endtask

  task automatic test_backpressure();
    logic [8:0] flits [6];
    logic [8:0] got [$];
    int pushed = 0, out1_seen = 0;
    bit acc;
    flits = '{9'b0_00000000, 9'b0_00000011, 9'b0_00000101, 9'b0_00000111, 9'b0_00001001, 9'b1_00001011};
    a_sel_ready = 1'b1;
    for (int cyc = 0; cyc < 32; cyc++) begin
      a_out_ready = (cyc >= 12) ? 2'b11 : 2'b10;
      a_in_valid = (pushed < 6);
      if (pushed < 6) a_in_data = flits[pushed]; else a_in_data = 9'd0;
      @(negedge CLK);
      acc = a_in_valid && a_in_ready;
      if (cyc == 11) begin
        checks++; if (a_in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%b exp=0", a_in_ready); end
        checks++; if (pushed != 5) begin failures++; $display("FAIL bp_accepted got=%0d exp=5", pushed); end
      end
      if (a_out_valid[0] && a_out_ready[0]) got.push_back(a_out_data[8:0]);
      if (a_out_valid[1]) out1_seen++;
      @(posedge CLK); #1;
      if (acc) pushed++;
    end
    a_in_valid = 1'b0;
    checks++; if (got.size() != 6) begin failures++; $display("FAIL bp_count got=%0d exp=6", got.size()); end
    for (int i = 0; i < 6; i++) begin
      logic [8:0] expv;
      expv = (i == 0) ? 9'b0_00000000 : flits[i];
      checks++;
      if (i >= got.size() || got[i] !== expv) begin
        failures++; $display("FAIL bp_flit%0d got=%b exp=%b", i, (i < got.size()) ? got[i] : 9'h1ff, expv);
      end
    end
    checks++; if (out1_seen != 0) begin failures++; $display("FAIL bp_out1_idle got=%0d exp=0", out1_seen); end
  endtask

  task automatic test_sel_backpressure();
    logic [8:0] flits [3];
    logic [9:0] got [$];
    logic [0:0] toks [$];
    int pushed = 0;
    bit acc;
    flits = '{9'b0_00000011, 9'b1_00010001, 9'b1_00000110};
    a_out_ready = 2'b11;
    for (int cyc = 0; cyc < 20; cyc++) begin
      a_sel_ready = (cyc >= 10);
      a_in_valid = (pushed < 3);
      if (pushed < 3) a_in_data = flits[pushed]; else a_in_data = 9'd0;
      @(negedge CLK);
      acc = a_in_valid && a_in_ready;
      if (cyc == 9) begin
        checks++; if (got.size() != 2) begin failures++; $display("FAIL selbp_first_pkt got=%0d exp=2", got.size()); end
        checks++; if (a_sel_valid !== 1'b1 || a_sel_data !== 1'b1) begin
          failures++; $display("FAIL selbp_held got=%b/%b exp=1/1", a_sel_valid, a_sel_data);
        end
      end
      if (a_out_valid[0]) got.push_back({1'b0, a_out_data[8:0]});
      if (a_out_valid[1]) got.push_back({1'b1, a_out_data[17:9]});
      if (a_sel_valid && a_sel_ready) toks.push_back(a_sel_data);
      @(posedge CLK); #1;
      if (acc) pushed++;
    end
    a_in_valid = 1'b0;
    checks++; if (got.size() != 3 || got[0] !== 10'b1_0_00000001 || got[1] !== 10'b1_1_00010001 || got[2] !== 10'b0_1_00000011) begin
      failures++; $display("FAIL selbp_order n=%0d first=%b exp port/flit 1:000000001 1:100010001 0:100000011", got.size(), (got.size() > 0) ? got[0] : 10'h3ff);
    end
    checks++; if (toks.size() != 2 || toks[0] !== 1'b1 || toks[1] !== 1'b0) begin
      failures++; $display("FAIL selbp_tokens n=%0d exp two tokens 1 then 0", toks.size());
    end
  endtask

  task automatic test_reset_mid_body();
    logic [8:0] flits [3];
    int pushed = 0, out0 = 0, out1 = 0, sels = 0;
    logic [8:0] d0 = 9'd0;
    bit acc;
    flits = '{9'b0_00000001, 9'b0_00000010, 9'b0_00000100};
    a_out_ready = 2'b00; a_sel_ready = 1'b1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      a_in_valid = (pushed < 3);
      if (pushed < 3) a_in_data = flits[pushed]; else a_in_data = 9'd0;
      @(negedge CLK);
      acc = a_in_valid && a_in_ready;
      @(posedge CLK); #1;
      if (acc) pushed++;
    end
    a_in_valid = 1'b0;
    RESET = 1'b1;
    #1;
    checks++; if (a_out_valid !== 2'b00) begin failures++; $display("FAIL midrst_out_valid got=%b exp=00", a_out_valid); end
    checks++; if (a_out_data !== 18'd0) begin failures++; $display("FAIL midrst_out_data got=%h exp=0", a_out_data); end
    checks++; if (a_sel_valid !== 1'b0 || a_in_ready !== 1'b0) begin
      failures++; $display("FAIL midrst_sel_in got=%b/%b exp=0/0", a_sel_valid, a_in_ready);
    end
`ifdef DECODER_LEAF_PKT_COUNT_EN
    checks++; if (a_pkt_count !== 32'd0) begin failures++; $display("FAIL midrst_pkt_count got=%h exp=0", a_pkt_count); end
`endif
    @(posedge CLK); #1;
    RESET = 1'b0;
    a_out_ready = 2'b11;
    pushed = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      a_in_valid = (pushed < 1);
      a_in_data = 9'b1_00000000;
      @(negedge CLK);
      acc = a_in_valid && a_in_ready;
      if (a_out_valid[0]) begin out0++; d0 = a_out_data[8:0]; end
      if (a_out_valid[1]) out1++;
      if (a_sel_valid) begin
        sels++;
        checks++; if (a_sel_data !== 1'b0) begin failures++; $display("FAIL midrst_sel_data got=%b exp=0", a_sel_data); end
      end
      @(posedge CLK); #1;
      if (acc) pushed++;
    end
    a_in_valid = 1'b0;
    checks++; if (out0 != 1 || d0 !== 9'b1_00000000) begin failures++; $display("FAIL midrst_new_pkt n=%0d got=%b exp=1 x 100000000", out0, d0); end
    checks++; if (out1 != 0) begin failures++; $display("FAIL midrst_no_resume got=%0d exp=0", out1); end
    checks++; if (sels != 1) begin failures++; $display("FAIL midrst_sel_tokens got=%0d exp=1", sels); end
`ifdef DECODER_LEAF_PKT_COUNT_EN
    checks++; if (a_pkt_count !== 32'h0000_0001) begin failures++; $display("FAIL midrst_pkt_count_after got=%h exp=00000001", a_pkt_count); end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "timeout");
  end

  initial begin
    RESET = 1'b1;
    a_in_data = 9'd0; a_in_valid = 1'b0; a_out_ready = 2'b11; a_sel_ready = 1'b1;
    b_in_data = 9'd0; b_in_valid = 1'b0; b_out_ready = 4'b1111; b_sel_ready = 1'b1;
    c_in_data = 9'd0; c_in_valid = 1'b0; c_out_ready = 3'b111; c_sel_ready = 1'b1;
    test_reset();
    test_basic_route();
    test_single_flit_stream();
    test_drop();
    test_backpressure();
    test_sel_backpressure();
    test_reset_mid_body();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
